// File: rtl/led_trail_pwm_if.sv
// LED pattern in / PWM drive out bundle between the light generator and the
// trail/PWM stage.
//   led_in  : on/off pattern from the upstream generator, 1 = lit
//   LED_out : per-LED PWM drive to the board, 1 = on
`timescale 1ns/1ps
interface led_trail_pwm_if #(
   parameter int unsigned N_LEDS = 10
);
   logic [N_LEDS-1:0] led_in;
   logic [N_LEDS-1:0] LED_out;

   // Upstream side: drives the pattern, observes the LEDs.
   modport master (output led_in, input LED_out);
   // Trail/PWM stage: consumes the pattern, drives the LEDs.
   modport slave  (input led_in, output LED_out);
endinterface

// File: rtl/led_trail_pwm.sv
// Per-LED PWM driver with a decaying "comet tail".
// A lit pattern bit loads its channel brightness to MAX; once the bit clears,
// brightness steps down by one on every decay tick until it reaches 0.
// Each LED is driven on while its brightness exceeds a shared free-running
// PWM counter, so duty = brightness / MAX.
//   CLK : system clock, rising edge
//   RST : asynchronous, active-high reset
//   bus : slave side of led_trail_pwm_if (led_in in, LED_out out)
`timescale 1ns/1ps
module led_trail_pwm #(
   parameter int unsigned N_LEDS    = 10,
   parameter int unsigned BRIGHT_W  = 4,
   parameter int unsigned DECAY_DIV = 500000
) (
   input  logic             CLK,
   input  logic             RST,
   led_trail_pwm_if.slave   bus
);

   localparam int unsigned MAX    = (1 << BRIGHT_W) - 1;
   localparam int unsigned DCNT_W = (DECAY_DIV > 2) ? $clog2(DECAY_DIV) : 1;

   logic [N_LEDS-1:0]   led_q;
   logic [BRIGHT_W-1:0] b [N_LEDS];
   logic [DCNT_W-1:0]   dcnt;
   logic [BRIGHT_W-1:0] pcnt;
   logic [N_LEDS-1:0]   led_out_q;
   logic                decay_tick_c;

   assign decay_tick_c = (dcnt == DCNT_W'(DECAY_DIV - 1));

   // Input capture of the upstream pattern.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         led_q <= '0;
      end else begin
         led_q <= bus.led_in;
      end
   end

   // Decay prescaler: one tick every DECAY_DIV cycles, phase global.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         dcnt <= '0;
      end else if (decay_tick_c) begin
         dcnt <= '0;
      end else begin
         dcnt <= dcnt + DCNT_W'(1);
      end
   end

   // PWM counter: 0..MAX-1, so a level of MAX is on for the whole period.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         pcnt <= '0;
      end else if (pcnt == BRIGHT_W'(MAX - 1)) begin
         pcnt <= '0;
      end else begin
         pcnt <= pcnt + BRIGHT_W'(1);
      end
   end

   // Brightness per channel: set wins over decay; decay saturates at 0.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < int'(N_LEDS); i++) begin
            b[i] <= '0;
         end
      end else begin
         for (int i = 0; i < int'(N_LEDS); i++) begin
            if (led_q[i]) begin
               b[i] <= BRIGHT_W'(MAX);
            end else if (decay_tick_c && (b[i] != '0)) begin
               b[i] <= b[i] - BRIGHT_W'(1);
            end
         end
      end
   end

   // Registered PWM compare.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         led_out_q <= '0;
      end else begin
         for (int i = 0; i < int'(N_LEDS); i++) begin
            led_out_q[i] <= (b[i] > pcnt);
         end
      end
   end

   assign bus.LED_out = led_out_q;

endmodule

// File: tb/tb_led_trail_pwm.sv
// Bench for led_trail_pwm with DECAY_DIV = 4.
// A cycle model predicts LED_out each edge into a queue that is compared on
// the falling edge; directed checks cover reset, set latency, fade, set/decay
// collision, asynchronous reset mid-fade and a bouncing window.
`timescale 1ns/1ps
module tb_led_trail_pwm;

   localparam int unsigned N   = 10;
   localparam int unsigned DD  = 4;
   localparam int          MAXB = 15;

   logic CLK;
   logic RST;

   led_trail_pwm_if #(.N_LEDS(N)) bus ();

   led_trail_pwm #(
      .N_LEDS    (N),
      .BRIGHT_W  (4),
      .DECAY_DIV (DD)
   ) dut (
      .CLK (CLK),
      .RST (RST),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // Reference model state
   logic [N-1:0] m_led_q;
   logic [N-1:0] m_out;
   logic [N-1:0] m_nxt;
   int           m_b [N];
   int           m_dcnt;
   int           m_pcnt;
   logic         m_tick;
   logic [N-1:0] sb_q [$];

   initial CLK = 1'b0;
   always #5 CLK = ~CLK;

   // Model: evaluates with pre-edge state, pushes the predicted LED_out.
   always @(posedge CLK or posedge RST) begin
      if (RST) begin
         m_led_q = '0;
         m_out   = '0;
         m_dcnt  = 0;
         m_pcnt  = 0;
         for (int i = 0; i < int'(N); i++) m_b[i] = 0;
         sb_q.delete();
      end else begin
         m_tick = (m_dcnt == int'(DD) - 1);
         for (int i = 0; i < int'(N); i++) m_nxt[i] = (m_b[i] > m_pcnt);
         for (int i = 0; i < int'(N); i++) begin
            if (m_led_q[i])                  m_b[i] = MAXB;
            else if (m_tick && m_b[i] > 0)   m_b[i] = m_b[i] - 1;
         end
         m_led_q = bus.led_in;
         m_dcnt  = m_tick ? 0 : m_dcnt + 1;
         m_pcnt  = (m_pcnt == MAXB - 1) ? 0 : m_pcnt + 1;
         m_out   = m_nxt;
         sb_q.push_back(m_out);
      end
   end

   // Scoreboard compare on the falling edge.
   always @(negedge CLK) begin
      logic [N-1:0] exp_v;
      if (RST) begin
         checks++;
         assert (bus.LED_out === '0) else begin
            errors++;
            $error("FAIL sb_reset: observed %h expected %h", bus.LED_out, 10'h000);
         end
      end else if (sb_q.size() > 0) begin
         exp_v = sb_q.pop_front();
         checks++;
         assert (bus.LED_out === exp_v) else begin
            errors++;
            $error("FAIL sb_led_out: observed %h expected %h", bus.LED_out, exp_v);
         end
      end
   end

   task automatic chk(input string tag, input logic [N-1:0] obs, input logic [N-1:0] exp_v);
      checks++;
      assert (obs === exp_v) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp_v);
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "timeout");
   end

   initial begin
      int cnt;
      logic [N-1:0] win;
      int pos_seq [15];

      // 1. Reset with all inputs lit, then quiet for 100 cycles
      RST = 1'b1;
      bus.led_in = 10'h3FF;
      repeat (3) begin
         @(negedge CLK);
         chk("rst_hold", bus.LED_out, 10'h000);
      end
      #1 RST = 1'b0;
      bus.led_in = 10'h000;
      repeat (100) @(negedge CLK);
      chk("rst_idle", bus.LED_out, 10'h000);

      // 2. Steady on: two-edge latency, then continuously on
      repeat (10) @(negedge CLK);
      bus.led_in = 10'h008;
      @(negedge CLK);
      chk("set_lat_k", bus.LED_out, 10'h000);
      @(negedge CLK);
      chk("set_lat_k1", bus.LED_out, 10'h000);
      repeat (30) begin
         @(negedge CLK);
         chk("steady_on", bus.LED_out, 10'h008);
      end
      bus.led_in = 10'h000;
      repeat (80) @(negedge CLK);
      chk("steady_faded", bus.LED_out, 10'h000);

      // 3. Fade after a one-cycle pulse on channel 0
      bus.led_in = 10'h001;
      @(negedge CLK);
      bus.led_in = 10'h000;
      @(negedge CLK);
      @(negedge CLK);
      chk("fade_on", bus.LED_out, 10'h001);
      repeat (17) @(negedge CLK);
      cnt = 0;
      repeat (15) begin
         @(negedge CLK);
         cnt += int'(bus.LED_out[0]);
      end
      checks++;
      assert (cnt > 0 && cnt < MAXB) else begin
         errors++;
         $error("FAIL fade_partial: observed %0d expected 1..14", cnt);
      end
      repeat (29) @(negedge CLK);
      repeat (36) begin
         @(negedge CLK);
         chk("fade_off", bus.LED_out, 10'h000);
      end

      // 4. Set coincides with decay tick on channel 5
      for (int i = 0; i < 8; i++) begin
         if (m_dcnt == int'(DD) - 2) break;
         @(negedge CLK);
      end
      bus.led_in = 10'h020;
      @(negedge CLK);
      bus.led_in = 10'h000;
      @(negedge CLK);
      chk("collide_b", N'(dut.b[5]), N'(MAXB));
      repeat (3) @(negedge CLK);
      chk("collide_hold", N'(dut.b[5]), N'(MAXB));
      repeat (80) @(negedge CLK);

      // 5. Reset mid-fade: channel 2 fading, channel 9 held on
      bus.led_in = 10'h204;
      repeat (2) @(negedge CLK);
      bus.led_in = 10'h200;
      for (int i = 0; i < 80; i++) begin
         @(negedge CLK);
         if (m_b[2] == 7) break;
      end
      chk("pre_rst_on", N'(bus.LED_out[9]), 10'h001);
      #2 RST = 1'b1;
      #1 chk("async_drop", bus.LED_out, 10'h000);
      bus.led_in = 10'h000;
      @(negedge CLK);
      #1 RST = 1'b0;
      repeat (40) begin
         @(negedge CLK);
         chk("post_rst_quiet", bus.LED_out, 10'h000);
      end

      // 6. Bouncing 3-lit window, 20 cycles per position
      for (int i = 0; i < 8; i++) pos_seq[i] = i;
      for (int i = 0; i < 7; i++) pos_seq[8 + i] = 6 - i;
      for (int s = 0; s < 15; s++) begin
         win = N'(10'h007 << pos_seq[s]);
         bus.led_in = win;
         repeat (20) @(negedge CLK);
         chk("bounce_lit", bus.LED_out & win, win);
      end
      bus.led_in = 10'h000;
      repeat (80) @(negedge CLK);
      chk("bounce_faded", bus.LED_out, 10'h000);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/led_trail_pwm.md
# led_trail_pwm

Downstream stage of the bouncing-light pattern generator. Takes its 10-bit on/off LED pattern and drives the physical LEDs through per-LED PWM, so each LED lights at full brightness while its pattern bit is set. After the bit clears, brightness decays stepwise to off, leaving a fading "comet tail" behind the moving light.

## Interface
- N_LEDS, 10, number of LED channels.
- BRIGHT_W, 4, brightness level width; MAX = 2^BRIGHT_W − 1 (15).
- DECAY_DIV, 500000, CLK cycles per decay step; legal range ≥ 2.

- CLK  input  1  system clock; all state updates on rising edge.
- RST  input  1  asynchronous, active-high reset.
- led_in  input  N_LEDS  pattern from the upstream light generator, synchronous to CLK, 1 = lit.
- LED_out  output  N_LEDS  PWM drive to the board LEDs, registered, 1 = on.

## Operation
- **Input register:** led_in is captured each cycle into led_q (N_LEDS bits).
- **Brightness registers:** one BRIGHT_W-bit register b[i] per channel.
- **Decay prescaler:** dcnt counts 0..DECAY_DIV−1 and wraps to 0. decay_tick = (dcnt == DECAY_DIV−1); it is high for exactly one cycle per DECAY_DIV cycles.
- **Brightness update, per channel, every cycle:**
  - led_q[i] = 1 → b[i] ← MAX. Set takes priority over decay in the same cycle.
  - Otherwise, if decay_tick and b[i] ≠ 0 → b[i] ← b[i] − 1.
  - Otherwise b[i] holds. b never underflows below 0 and never exceeds MAX.
- **PWM counter:** pcnt counts 0..MAX−1 and wraps, giving a period of MAX cycles. It is shared by all channels and runs free regardless of input.
- **Output compare:** LED_out[i] ← (b[i] > pcnt), registered.
  - Duty = b[i]/MAX exactly over any aligned MAX-cycle window.
  - b = MAX gives always on; b = 0 gives always off.
- **Comparison width:** unsigned, BRIGHT_W bits throughout.
- **Reset (asynchronous):** led_q, all b[i], dcnt, pcnt and LED_out go to 0 immediately on RST high.
  - Reset mid-fade discards all brightness state.
  - After RST deasserts, counting restarts from 0 on the next CLK edge.

## Timing
- **Latency from set:** led_in[i] = 1 before edge k → led_q at k → b[i] = MAX at k+1 → LED_out[i] = 1 from edge k+2, continuously while the bit stays set.
- **Release:** led_in[i] falling before edge k → b[i] holds MAX until the first decay_tick evaluated at or after edge k+1, then decrements by 1 per tick.
- **Full fade:** from MAX to 0 takes MAX ticks, i.e. between (MAX−1)·DECAY_DIV+1 and MAX·DECAY_DIV cycles.
- **PWM alignment:** a change in b[i] appears in LED_out one cycle later. There is no glitch suppression at PWM period boundaries; duty is correct from the first full period after the change.
- **Prescaler phase:** dcnt phase is global. After reset, the first decay_tick occurs on the edge where dcnt reaches DECAY_DIV−1, i.e. the DECAY_DIV-th edge after reset release.
- **Channel independence:** each channel is independent. All channels may set, decay, or hold in the same cycle.

## Test plan
All scenarios use DECAY_DIV = 4 unless stated.

1. **Reset:** assert RST for 3 cycles with led_in = 10'h3FF, then release with led_in = 0. Required: LED_out = 0 throughout, and b stays 0 through 100 cycles.
2. **Steady on:** hold led_in[3] = 1 from cycle 10. Required: LED_out[3] = 1 from cycle 12 onward, every cycle; all other outputs 0.
3. **Fade:** pulse led_in[0] = 1 for 1 cycle, then 0. Required:
   - b[0] steps 15→14→…→0, one step per decay_tick, 15 steps in ≤ 60 cycles;
   - high-cycle count of LED_out[0] in each aligned 15-cycle PWM window equals b[0] for that window (when held constant);
   - LED_out[0] = 0 permanently once b[0] = 0.
4. **Set/decay collision:** drive led_q[5] = 1 on the cycle where decay_tick = 1. Required: b[5] = 15, no decrement.
5. **Reset mid-fade:** after a release, wait until b[2] = 7, then pulse RST for 1 cycle mid-PWM period. Required: LED_out drops to 0 asynchronously, without waiting for CLK; b[2] = 0 after reset; no output activity until a new set.
6. **Bouncing pattern:** apply the upstream 3-lit window shifting by 1 bit every 20 cycles left to right and back. Required:
   - lit channels are always on;
   - trailing channels show strictly decreasing duty with distance behind the window;
   - no channel exceeds MAX or wraps from 0 to 15.
